// File: rtl/pipe_debug_ctrl.sv
// pipe_debug_ctrl: loads a program byte-wise into instruction memory and gates
// the pipeline clock enable for run / single-step debugging until halt.
module pipe_debug_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  input  logic [1:0]            i_cmd,
  input  logic                  i_cmd_valid,
  input  logic                  i_halt_wb,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic                  o_loading,
  output logic                  o_instr_we,
  output logic                  o_pipe_enable,
  output logic [31:0]           o_cycle_count,
  output logic [2:0]            o_state,
  output logic                  o_done
);
  localparam int IW = IMEM_DEPTH > 1 ? $clog2(IMEM_DEPTH) : 1;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_RUN, S_STEP, S_DONE} state_t;
  state_t state;
  logic [IW-1:0] word_idx;
  logic [1:0] byte_cnt;
  logic [DATA_WIDTH-9:0] word_buf;
  logic [DATA_WIDTH-1:0] assembled;
  logic abort, cmd_run, cmd_step, accept;
  assign cmd_run  = i_cmd_valid && i_cmd == 2'b01;
  assign cmd_step = i_cmd_valid && i_cmd == 2'b10;
  // ABORT is a no-op in IDLE, so it only suppresses bytes once loading has begun
  assign abort = i_cmd_valid && i_cmd == 2'b11 && state != S_IDLE;
  assign o_byte_ready = (state == S_IDLE || state == S_LOAD) && !o_instr_we && !abort;
  assign accept = i_byte_valid && o_byte_ready;
  assign assembled = {word_buf, i_byte};
  assign o_loading = state == S_LOAD;
  assign o_done = state == S_DONE;
  assign o_state = state;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_IDLE;
      word_idx <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
      o_instruccion <= '0;
      o_address <= '0;
      o_instr_we <= 1'b0;
      o_pipe_enable <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      o_instr_we <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        word_idx <= '0;
        byte_cnt <= '0;
        word_buf <= '0;
        o_pipe_enable <= 1'b0;
        o_cycle_count <= '0;
      end else begin
        if (o_pipe_enable && o_cycle_count != '1)
          o_cycle_count <= o_cycle_count + 32'd1;
        if (accept) begin
          word_buf <= assembled[DATA_WIDTH-9:0];
          byte_cnt <= byte_cnt + 2'd1;
          if (state == S_IDLE)
            state <= S_LOAD;
          if (byte_cnt == 2'd3) begin
            o_instr_we <= 1'b1;
            o_instruccion <= assembled;
            o_address <= DATA_WIDTH'(word_idx) << 2;
          end
        end
        // the write cycle decides whether loading is complete
        if (o_instr_we) begin
          word_idx <= word_idx + IW'(1);
          if (o_instruccion == HALT_WORD || word_idx == IW'(IMEM_DEPTH - 1))
            state <= S_READY;
        end
        case (state)
          S_READY: begin
            state <= cmd_run ? S_RUN : cmd_step ? S_STEP : S_READY;
            o_pipe_enable <= cmd_run || cmd_step;
          end
          S_RUN: begin
            state <= i_halt_wb && o_pipe_enable ? S_DONE : cmd_step ? S_STEP : S_RUN;
            o_pipe_enable <= !(i_halt_wb && o_pipe_enable) && !cmd_step;
          end
          S_STEP: begin
            state <= i_halt_wb && o_pipe_enable ? S_DONE : cmd_run ? S_RUN : S_STEP;
            o_pipe_enable <= !(i_halt_wb && o_pipe_enable) && (cmd_run || cmd_step);
          end
          default: o_pipe_enable <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: doc/pipe_debug_ctrl.md
PIPE_DEBUG_CTRL -- requirements
Module: pipe_debug_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the instruction word and address width.
REQ-002 Parameter IMEM_DEPTH, default 256, SHALL set the instruction memory depth in words.
REQ-003 Parameter HALT_WORD, default 32'hFFFFFFFF, SHALL set the halt instruction encoding.
REQ-004 i_clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_byte  in  8  SHALL carry one program byte.
REQ-007 i_byte_valid  in  1  SHALL qualify i_byte.
REQ-008 o_byte_ready  out  1  SHALL mark the cycles in which a byte is accepted.
REQ-009 i_cmd  in  2  SHALL carry the command: 01 RUN, 10 STEP, 11 ABORT, 00 no-op.
REQ-010 i_cmd_valid  in  1  SHALL qualify i_cmd for one cycle.
REQ-011 i_halt_wb  in  1  SHALL indicate that the halt instruction is in write-back.
REQ-012 o_instruccion  out  DATA_WIDTH  SHALL carry the assembled instruction word.
REQ-013 o_address  out  DATA_WIDTH  SHALL carry the byte address (word_idx*4).
REQ-014 o_loading  out  1  SHALL be high while the controller is in state LOAD.
REQ-015 o_instr_we  out  1  SHALL be a one-cycle instruction-memory write strobe.
REQ-016 o_pipe_enable  out  1  SHALL be the pipeline clock enable.
REQ-017 o_cycle_count  out  32  SHALL count enabled pipeline cycles.
REQ-018 o_state  out  3  SHALL encode the state: IDLE=0, LOAD=1, READY=2, RUN=3, STEP=4, DONE=5.
REQ-019 o_done  out  1  SHALL be high in state DONE.

Function
REQ-020 A byte SHALL be accepted when i_byte_valid && o_byte_ready.
REQ-021 o_byte_ready SHALL be 1 in IDLE and LOAD, except in the cycle o_instr_we is high, and 0 in all other states.
REQ-022 In IDLE, an accepted byte SHALL be byte 0 of word 0, and the next state SHALL be LOAD.
REQ-023 Bytes SHALL assemble big-endian: the first byte goes to [31:24] and the fourth to [7:0].
REQ-024 The cycle after the fourth byte is accepted, o_instr_we=1 with o_instruccion=word and o_address=word_idx*4, and word_idx SHALL then increment.
REQ-025 After that write, the next state SHALL be READY if word==HALT_WORD or word_idx==IMEM_DEPTH-1; otherwise the state SHALL remain LOAD.
REQ-026 o_instruccion and o_address SHALL hold their values between writes.
REQ-027 From READY, RUN SHALL move to RUN, STEP SHALL move to STEP, and ABORT SHALL move to IDLE.
REQ-028 In RUN, o_pipe_enable SHALL be 1 every cycle, registered so it rises the cycle after RUN is entered.
REQ-029 In STEP, each STEP command SHALL produce exactly one cycle of o_pipe_enable=1 on the next cycle.
REQ-030 Entry into STEP from READY SHALL itself produce one enable pulse.
REQ-031 A STEP command arriving during a step pulse SHALL still yield its own pulse.
REQ-032 In STEP, RUN SHALL move to RUN; in RUN, STEP SHALL move to STEP with no further enables until the next STEP command.
REQ-033 i_halt_wb=1 in a cycle with o_pipe_enable=1 SHALL move to DONE, with o_pipe_enable=0 from the next cycle; i_halt_wb with enable=0 SHALL be ignored.
REQ-034 o_cycle_count SHALL increment in every cycle with o_pipe_enable=1, including the halt cycle, and SHALL saturate at 32'hFFFFFFFF.
REQ-035 ABORT in any state other than IDLE SHALL move to IDLE and clear word_idx, the partial word, the byte counter and o_cycle_count.
REQ-036 ABORT SHALL win over a simultaneous byte, halt or step.
REQ-037 In IDLE, ABORT SHALL be a no-op.
REQ-038 Commands other than ABORT SHALL be ignored in IDLE, LOAD and DONE, and RUN SHALL be ignored in RUN.
REQ-039 Bytes presented outside IDLE and LOAD SHALL be ignored and not acknowledged.

Reset
REQ-040 i_reset=0 SHALL immediately force IDLE, with all outputs 0 except o_byte_ready=1, and clear word_idx, the byte counter and o_cycle_count.
REQ-041 Reset asserted mid-word or mid-run SHALL discard all progress, and operation SHALL restart at word_idx=0 after release.

Verification
REQ-042 Bytes 20,08,00,05 then FF,FF,FF,FF -> we at address 0 with word 0x20080005, we at address 4 with word 0xFFFFFFFF, state READY, o_byte_ready=0.
REQ-043 READY, then RUN, then i_halt_wb asserted on the 7th enabled cycle -> o_cycle_count=7, state DONE, o_pipe_enable=0 the next cycle.
REQ-044 READY, then STEP, then two more STEP commands spaced 3 cycles apart -> exactly 3 single-cycle enable pulses, o_cycle_count=3.
REQ-045 IMEM_DEPTH=4 with 16 non-halt bytes -> writes at 0,4,8,C, then READY; a 17th byte is not accepted.
REQ-046 ABORT in the same cycle as the 4th byte -> no o_instr_we, state IDLE; the next word is written at address 0.
REQ-047 Reset pulsed low during RUN with count=5 -> o_cycle_count=0, state IDLE and o_pipe_enable=0 with no clock edge required.
